spi_io_mux: RTL and testbench

Parametrised SPI word-to-bus bridge and module selector, the successor to the single-address-word SPI I/O selector. It sits between an SPI slave word interface (`m_spi_*` in, `s_spi_*` out) and up to 64 register-mapped modules. It decodes a command word and a configurable number of extended address words. It supports optional address auto-increment bursts, a configurable read latency and a masked, sticky status-change interrupt, and it flags out-of-range module addresses.

---
 rtl/spi_io_pkg.sv | 27 ++
 rtl/spi_rd_pipe.sv | 45 ++++
 rtl/spi_io_mux.sv | 217 +++++++++++++++++++++
 tb/tb_spi_io_mux.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_io_pkg.sv
// Shared definitions for the SPI I/O mux slice: a sizing helper, the command
// flag positions and the bridge FSM encoding.
package spi_io_pkg;

   localparam int MAX_MODULES = 64;

   // Command flag positions, counted down from the MSB of an SPI word.
   localparam int CMD_WR  = 1;
   localparam int CMD_INC = 2;
   localparam int CMD_EXT = 3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   // Ceiling log2 that never returns less than 1, so a single module still
   // gets a one-bit index field.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/spi_rd_pipe.sv
// Read-latency tracker: delays each read strobe by LATENCY cycles, captures the
// module read data at that point and presents it with a one-cycle valid.
module spi_rd_pipe #(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             strobe_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   logic [LATENCY-1:0] stageQ, stageD;
   logic               validQ;
   logic [WIDTH-1:0]   dataQ;

   if (LATENCY == 1) begin : gSingle
      assign stageD = strobe_i;
   end else begin : gChain
      assign stageD = {stageQ[LATENCY-2:0], strobe_i};
   end

   // A flush drops every strobe in flight so a cancelled read never answers.
   always_ff @(posedge clk) begin
      if (rst) begin
         stageQ <= '0;
         validQ <= 1'b0;
         dataQ  <= '0;
      end else if (flush_i) begin
         stageQ <= '0;
         validQ <= 1'b0;
      end else begin
         stageQ <= stageD;
         validQ <= stageQ[LATENCY-1];
         if (stageQ[LATENCY-1]) dataQ <= data_i;
      end
   end

   assign valid_o = validQ;
   assign data_o  = dataQ;

endmodule

// File: rtl/spi_io_mux.sv
// SPI word-to-bus bridge: decodes a command plus optional extended address
// words, drives register-bus strobes, selects one of NR_MODULES and raises a
// masked status-change interrupt.
module spi_io_mux
   import spi_io_pkg::*;
#(
   parameter int SPI_DATA_WIDTH = 8,
   parameter int NR_MODULES     = 5,
   parameter int EXT_ADDR_WORDS = 1,
   parameter int RD_LATENCY     = 1,
   parameter logic [SPI_DATA_WIDTH-1:0] IRQ_MASK = '1,
   localparam int NR_MODULES_WIDTH = clog2(NR_MODULES),
   localparam int AW = (SPI_DATA_WIDTH - 3) + EXT_ADDR_WORDS * SPI_DATA_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [SPI_DATA_WIDTH-1:0] m_spi_d,
   input  logic                      m_spi_dv,
   output logic [SPI_DATA_WIDTH-1:0] s_spi_d,
   output logic                      s_spi_dv,
   input  logic                      spi_active,
   input  logic [SPI_DATA_WIDTH-1:0] spi_status,
   output logic                      spi_rd,
   output logic                      spi_wr,
   output logic [AW-1:0]             spi_addr,
   output logic [SPI_DATA_WIDTH-1:0] spi_data_wr,
   input  logic [SPI_DATA_WIDTH-1:0] spi_data_rd,
   output logic [NR_MODULES-1:0]     select,
   output logic                      spi_addr_err,
   output logic                      spi_intr
);

   localparam int D  = SPI_DATA_WIDTH;
   localparam int UW = D - 3;
   localparam int LW = AW - NR_MODULES_WIDTH;

   if (D < 3 + NR_MODULES_WIDTH || NR_MODULES < 1 || NR_MODULES > MAX_MODULES ||
       EXT_ADDR_WORDS < 1 || EXT_ADDR_WORDS > 3 || RD_LATENCY < 1 || RD_LATENCY > 4) begin : gBadParams
      $fatal(1, "spi_io_mux: illegal parameter combination");
   end

   logic [1:0]    stateQ, stateD;
   logic [AW-1:0] addrQ, addrD;
   logic [1:0]    wordCntQ, wordCntD;
   logic          wrModeQ, wrModeD;
   logic          incQ, incD;
   logic          errQ, errD;
   logic          rdPulseQ, rdPulseD;
   logic          wrPulseQ, wrPulseD;
   logic [D-1:0]  dataWrQ, dataWrD;
   logic          respDvQ, respDvD;
   logic [D-1:0]  respQ, respD;
   logic [D-1:0]  statusQ;
   logic          primedQ;
   logic [D-1:0]  chgQ, chgD;
   logic          intrQ, intrD;
   logic          cmdSeen;
   logic [AW-1:0] cmdAddr;
   logic          pipeValid;
   logic [D-1:0]  pipeData;
   logic [D-1:0]  rdCapture;

   function automatic logic indexBad(input logic [AW-1:0] a);
      return 32'(a[AW-1 -: NR_MODULES_WIDTH]) >= 32'(NR_MODULES);
   endfunction

   assign cmdSeen = spi_active && m_spi_dv && (stateQ == ST_IDLE);
   assign cmdAddr = {m_spi_d[UW-1:0], {(AW-UW){1'b0}}};

   // Bridge FSM; dropping chip-select overrides everything at the bottom.
   always_comb begin
      stateD   = stateQ;
      addrD    = addrQ;
      wordCntD = wordCntQ;
      wrModeD  = wrModeQ;
      incD     = incQ;
      errD     = errQ;
      rdPulseD = 1'b0;
      wrPulseD = 1'b0;
      dataWrD  = dataWrQ;
      respDvD  = 1'b0;
      respD    = respQ;

      if ((rdPulseQ || wrPulseQ) && incQ) addrD[LW-1:0] = addrQ[LW-1:0] + LW'(1);

      case (stateQ)
         ST_IDLE: begin
            if (cmdSeen) begin
               wrModeD  = m_spi_d[D-CMD_WR];
               incD     = m_spi_d[D-CMD_INC];
               addrD    = cmdAddr;
               errD     = indexBad(cmdAddr);
               wordCntD = 2'd0;
               respDvD  = 1'b1;
               respD    = spi_status;
               if (m_spi_d[D-CMD_EXT]) begin
                  stateD = ST_ADDR;
               end else begin
                  stateD   = ST_DATA;
                  rdPulseD = !m_spi_d[D-CMD_WR];
               end
            end
         end
         ST_ADDR: begin
            if (m_spi_dv) begin
               for (int i = 0; i < EXT_ADDR_WORDS; i++) begin
                  if (wordCntQ == 2'(i)) addrD[(EXT_ADDR_WORDS-1-i)*D +: D] = m_spi_d;
               end
               if (wordCntQ == 2'(EXT_ADDR_WORDS - 1)) begin
                  stateD   = ST_DATA;
                  wordCntD = 2'd0;
                  rdPulseD = !wrModeQ;
               end else begin
                  wordCntD = wordCntQ + 2'd1;
               end
            end
         end
         ST_DATA: begin
            if (m_spi_dv) begin
               if (wrModeQ) begin
                  wrPulseD = 1'b1;
                  dataWrD  = m_spi_d;
               end else begin
                  rdPulseD = 1'b1;
               end
            end
         end
         default: stateD = ST_IDLE;
      endcase

      if (!spi_active) begin
         stateD   = ST_IDLE;
         addrD    = '0;
         wordCntD = 2'd0;
         errD     = 1'b0;
         rdPulseD = 1'b0;
         wrPulseD = 1'b0;
         respDvD  = 1'b0;
      end
   end

   // A change landing on the command cycle survives the clear.
   always_comb begin
      chgD  = (cmdSeen ? '0 : chgQ) | (primedQ ? ((spi_status ^ statusQ) & IRQ_MASK) : '0);
      intrD = cmdSeen ? 1'b0 : |chgQ;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ   <= ST_IDLE;
         addrQ    <= '0;
         wordCntQ <= 2'd0;
         wrModeQ  <= 1'b0;
         incQ     <= 1'b0;
         errQ     <= 1'b0;
         rdPulseQ <= 1'b0;
         wrPulseQ <= 1'b0;
         dataWrQ  <= '0;
         respDvQ  <= 1'b0;
         respQ    <= '0;
         statusQ  <= '0;
         primedQ  <= 1'b0;
         chgQ     <= '0;
         intrQ    <= 1'b0;
      end else begin
         stateQ   <= stateD;
         addrQ    <= addrD;
         wordCntQ <= wordCntD;
         wrModeQ  <= wrModeD;
         incQ     <= incD;
         errQ     <= errD;
         rdPulseQ <= rdPulseD;
         wrPulseQ <= wrPulseD;
         dataWrQ  <= dataWrD;
         respDvQ  <= respDvD;
         respQ    <= respD;
         statusQ  <= spi_status;
         primedQ  <= 1'b1;
         chgQ     <= chgD;
         intrQ    <= intrD;
      end
   end

   // Out-of-range reads still answer, but with zero instead of bus data.
   assign rdCapture = errQ ? '0 : spi_data_rd;

   spi_rd_pipe #(
      .WIDTH   (D),
      .LATENCY (RD_LATENCY)
   ) uRdPipe (
      .clk      (clk),
      .rst      (rst),
      .flush_i  (!spi_active),
      .strobe_i (rdPulseQ),
      .data_i   (rdCapture),
      .valid_o  (pipeValid),
      .data_o   (pipeData)
   );

   always_comb begin
      select = '0;
      for (int i = 0; i < NR_MODULES; i++) begin
         select[i] = (stateQ == ST_DATA) &&
                     (addrQ[AW-1 -: NR_MODULES_WIDTH] == NR_MODULES_WIDTH'(i));
      end
   end

   assign spi_rd       = rdPulseQ && !errQ;
   assign spi_wr       = wrPulseQ && !errQ;
   assign spi_addr     = addrQ;
   assign spi_data_wr  = dataWrQ;
   assign spi_addr_err = errQ;
   assign spi_intr     = intrQ;
   assign s_spi_dv     = respDvQ || pipeValid;
   assign s_spi_d      = (stateQ == ST_IDLE) ? chgQ : (pipeValid ? pipeData : respQ);

endmodule

// File: tb/tb_spi_io_mux.sv
// Randomised scoreboard bench for spi_io_mux (D=8, 5 modules, one extended
// address word, read latency 3, interrupt mask 0x0F).
module tb_spi_io_mux;

   localparam int LAT = 3;
   localparam int GAP = 8;
   localparam logic [7:0] MASK = 8'h0F;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } respT;

   typedef struct {
      logic        isWr;
      logic [12:0] addr;
      logic [7:0]  data;
      logic [4:0]  sel;
      int          cyc;
   } busT;

   logic        clock;
   logic        reset;
   logic [7:0]  mSpiD;
   logic        mSpiDv;
   logic [7:0]  sSpiD;
   logic        sSpiDv;
   logic        spiActive;
   logic [7:0]  spiStatus;
   logic        spiRd;
   logic        spiWr;
   logic [12:0] spiAddr;
   logic [7:0]  spiDataWr;
   logic [7:0]  spiDataRd;
   logic [4:0]  select;
   logic        spiAddrErr;
   logic        spiIntr;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   respT respQ[$];
   busT  busQ[$];
   respT monResp;
   busT  monBus;

   logic [7:0]  mem [0:8191];
   logic [12:0] rdLatch = '0;
   logic [7:0]  dataWords [4];

   spi_io_mux #(
      .SPI_DATA_WIDTH (8),
      .NR_MODULES     (5),
      .EXT_ADDR_WORDS (1),
      .RD_LATENCY     (LAT),
      .IRQ_MASK       (MASK)
   ) dut (
      .clk          (clock),
      .rst          (reset),
      .m_spi_d      (mSpiD),
      .m_spi_dv     (mSpiDv),
      .s_spi_d      (sSpiD),
      .s_spi_dv     (sSpiDv),
      .spi_active   (spiActive),
      .spi_status   (spiStatus),
      .spi_rd       (spiRd),
      .spi_wr       (spiWr),
      .spi_addr     (spiAddr),
      .spi_data_wr  (spiDataWr),
      .spi_data_rd  (spiDataRd),
      .select       (select),
      .spi_addr_err (spiAddrErr),
      .spi_intr     (spiIntr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Register-mapped module model: the read address is latched on the strobe
   // and its contents stay on the read bus until the next strobe.
   always @(posedge clock) if (spiRd) rdLatch <= spiAddr;
   assign spiDataRd = mem[rdLatch];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: every DUT response and bus strobe is matched against the
   // oldest entry the stimulus side queued for it.
   always @(negedge clock) begin
      if (!reset) begin
         if (sSpiDv) begin
            if (respQ.size() == 0) begin
               checkOutput("unexpected_s_spi_dv", 64'(sSpiD), 64'hFFFF);
            end else begin
               monResp = respQ.pop_front();
               checkOutput("s_spi_d", 64'(sSpiD), 64'(monResp.data));
               checkOutput("s_spi_dv_cycle", 64'(cyc), 64'(monResp.cyc));
            end
         end
         if (spiRd || spiWr) begin
            if (busQ.size() == 0) begin
               checkOutput("unexpected_bus_strobe", {62'd0, spiWr, spiRd}, 64'd0);
            end else begin
               monBus = busQ.pop_front();
               checkOutput("bus_kind", {62'd0, spiWr, spiRd}, {62'd0, monBus.isWr, !monBus.isWr});
               checkOutput("bus_addr", 64'(spiAddr), 64'(monBus.addr));
               checkOutput("bus_select", 64'(select), 64'(monBus.sel));
               checkOutput("bus_cycle", 64'(cyc), 64'(monBus.cyc));
               if (monBus.isWr) checkOutput("bus_wdata", 64'(spiDataWr), 64'(monBus.data));
            end
         end
      end
   end

   // Address of the k-th access of a burst: the module index never moves and
   // the offset counts up modulo 1024 when auto-increment is on.
   function automatic logic [12:0] addrOf(input logic [12:0] base, input logic inc, input int k);
      logic [9:0] low;
      low = inc ? 10'(int'(base[9:0]) + k) : base[9:0];
      return {base[12:10], low};
   endfunction

   task automatic applyStimulus(input logic [7:0] w, output int c);
      @(negedge clock);
      mSpiD  = w;
      mSpiDv = 1'b1;
      c      = cyc;
   endtask

   task automatic idleGap();
      @(negedge clock);
      mSpiDv = 1'b0;
      repeat (GAP) @(negedge clock);
   endtask

   task automatic pushRead(input logic [12:0] a, input logic bad, input logic [4:0] sel, input int rc);
      busT  b;
      respT r;
      if (!bad) begin
         b.isWr = 1'b0;
         b.addr = a;
         b.data = 8'h00;
         b.sel  = sel;
         b.cyc  = rc;
         busQ.push_back(b);
      end
      r.data = bad ? 8'h00 : mem[a];
      r.cyc  = rc + LAT + 1;
      respQ.push_back(r);
   endtask

   task automatic runTransaction(input logic [7:0] cmd, input logic [7:0] ext, input int nData,
                                 input logic [7:0] status);
      logic        isWr, inc, isExt, bad;
      logic [12:0] base;
      logic [2:0]  idx;
      logic [4:0]  sel;
      int          c, k;
      respT        r;
      busT         b;
      @(negedge clock);
      spiStatus = status;
      repeat (2) @(negedge clock);
      isWr  = cmd[7];
      inc   = cmd[6];
      isExt = cmd[5];
      base  = {cmd[4:0], isExt ? ext : 8'h00};
      idx   = base[12:10];
      bad   = (idx >= 3'd5);
      sel   = bad ? 5'd0 : 5'(1 << idx);
      applyStimulus(cmd, c);
      r.data = status;
      r.cyc  = c + 1;
      respQ.push_back(r);
      if (isExt) begin
         idleGap();
         applyStimulus(ext, c);
      end
      k = 0;
      if (!isWr) begin
         pushRead(addrOf(base, inc, k), bad, sel, c + 1);
         k++;
      end
      idleGap();
      for (int i = 0; i < nData; i++) begin
         applyStimulus(dataWords[i], c);
         if (isWr) begin
            if (!bad) begin
               b.isWr = 1'b1;
               b.addr = addrOf(base, inc, k);
               b.data = dataWords[i];
               b.sel  = sel;
               b.cyc  = c + 1;
               busQ.push_back(b);
            end
         end else begin
            pushRead(addrOf(base, inc, k), bad, sel, c + 1);
         end
         k++;
         idleGap();
      end
   endtask

   task automatic endTransaction();
      @(negedge clock);
      spiActive = 1'b0;
      @(negedge clock);
      checkOutput("abort_addr", 64'(spiAddr), 64'd0);
      checkOutput("abort_select", 64'(select), 64'd0);
      checkOutput("abort_err", 64'(spiAddrErr), 64'd0);
      spiActive = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int   c;
      respT r;
      busT  b;
      logic [7:0] s;

      for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
      mem[13'h01FF] = 8'hA5;
      reset     = 1'b1;
      mSpiD     = 8'h00;
      mSpiDv    = 1'b0;
      spiActive = 1'b0;
      spiStatus = 8'h00;
      repeat (3) @(negedge clock);
      checkOutput("reset_outputs_a", {31'd0, sSpiD, sSpiDv, spiRd, spiWr, spiAddr},
                  64'd0);
      checkOutput("reset_outputs_b", {48'd0, spiDataWr, select, spiAddrErr, spiIntr}, 64'd0);
      reset     = 1'b0;
      spiActive = 1'b1;
      repeat (3) @(negedge clock);

      // Short write with auto-increment to module 2.
      dataWords[0] = 8'h11;
      dataWords[1] = 8'h22;
      runTransaction(8'hC8, 8'h00, 2, 8'h3C);
      checkOutput("short_write_select", 64'(select), 64'b00100);
      checkOutput("short_write_final_addr", 64'(spiAddr), 64'h0802);
      endTransaction();

      // Extended read from module 0 at 0x01FF.
      runTransaction(8'h21, 8'hFF, 0, 8'h5A);
      checkOutput("ext_read_addr", 64'(spiAddr), 64'h01FF);
      checkOutput("ext_read_select", 64'(select), 64'b00001);
      endTransaction();

      // Offset wraps inside module 1.
      runTransaction(8'h67, 8'hFF, 2, 8'h5A);
      checkOutput("wrap_select", 64'(select), 64'b00010);
      checkOutput("wrap_final_addr", 64'(spiAddr), 64'h0402);
      endTransaction();

      // Module index 7 is out of range: no write strobe, error flagged.
      dataWords[0] = 8'h55;
      runTransaction(8'hDC, 8'h00, 1, 8'h5A);
      checkOutput("oor_err", 64'(spiAddrErr), 64'd1);
      checkOutput("oor_select", 64'(select), 64'd0);
      endTransaction();
      dataWords[0] = 8'h77;
      runTransaction(8'hC8, 8'h00, 1, 8'h5A);
      checkOutput("oor_cleared_by_cmd", 64'(spiAddrErr), 64'd0);
      endTransaction();

      // Interrupt: masked bit stays quiet, unmasked bit fires two cycles later.
      s = spiStatus;
      @(negedge clock);
      spiStatus = s ^ 8'h10;
      repeat (4) @(negedge clock);
      checkOutput("irq_masked_bit", 64'(spiIntr), 64'd0);
      checkOutput("irq_masked_chg", 64'(sSpiD), 64'd0);
      spiStatus = spiStatus ^ 8'h02;
      @(negedge clock);
      checkOutput("irq_not_early", 64'(spiIntr), 64'd0);
      @(negedge clock);
      checkOutput("irq_raised", 64'(spiIntr), 64'd1);
      checkOutput("irq_idle_chg", 64'(sSpiD), 64'h02);
      runTransaction(8'h08, 8'h00, 0, spiStatus);
      checkOutput("irq_cleared_by_cmd", 64'(spiIntr), 64'd0);
      endTransaction();

      // Abort between the read strobe and its capture: no answer may appear.
      applyStimulus(8'h08, c);
      r.data = spiStatus;
      r.cyc  = c + 1;
      respQ.push_back(r);
      b.isWr = 1'b0;
      b.addr = 13'h0800;
      b.data = 8'h00;
      b.sel  = 5'b00100;
      b.cyc  = c + 1;
      busQ.push_back(b);
      @(negedge clock);
      mSpiDv = 1'b0;
      @(negedge clock);
      spiActive = 1'b0;
      @(negedge clock);
      checkOutput("abort_mid_addr", 64'(spiAddr), 64'd0);
      checkOutput("abort_mid_select", 64'(select), 64'd0);
      checkOutput("abort_mid_idle_chg", 64'(sSpiD), 64'd0);
      repeat (LAT + 4) @(negedge clock);
      spiActive = 1'b1;
      repeat (2) @(negedge clock);

      // Randomised transactions of every command flavour.
      for (int t = 0; t < 24; t++) begin
         for (int i = 0; i < 4; i++) dataWords[i] = 8'($urandom);
         runTransaction(8'($urandom), 8'($urandom), $urandom_range(0, 3), 8'($urandom));
         endTransaction();
      end

      repeat (GAP) @(negedge clock);
      checkOutput("resp_queue_drained", 64'(respQ.size()), 64'd0);
      checkOutput("bus_queue_drained", 64'(busQ.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
